// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Purpose  : Shared constants, state type and helpers for the mesh router.
// Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int DIR_N = 0;
    localparam int DIR_S = 1;
    localparam int DIR_W = 2;
    localparam int DIR_E = 3;
    localparam int DIR_L = 4;

    localparam int NOC_DATA_W  = 16;
    localparam int NOC_CREDITS = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } port_state_t;

    // Successor of an input index, wrapping modulo the number of inputs.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_rr_arbiter
// Purpose  : Combinational round-robin pick: first requester at/after i_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int N     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_grant                         = '0;
                o_grant[(int'(i_ptr) + k) % N]  = 1'b1;
                o_idx                           = IDX_W'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_output_port.sv
`default_nettype none
// ============================================================================
// Module   : noc_output_port
// Purpose  : Per-output router slice: wormhole RR arbitration, credits, output
//            register. Optional NOC_OUTPUT_PORT_STATS_EN adds flit/pkt counters.
// Revision : 1.0 - initial release
// ============================================================================
module noc_output_port
    import noc_pkg::*;
#(
    parameter int NUM_IN  = 5,
    parameter int DATA_W  = NOC_DATA_W,
    parameter int CREDITS = NOC_CREDITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         req_i,
    input  logic [NUM_IN-1:0]         tail_i,
    input  logic [NUM_IN*DATA_W-1:0]  data_i,
    output logic [NUM_IN-1:0]         grant_o,
    input  logic                      credit_i,
    output logic [DATA_W-1:0]         data_o,
    output logic                      valid_o,
    output logic [$clog2(NUM_IN)-1:0] owner_o,
    output logic                      err_o
`ifdef NOC_OUTPUT_PORT_STATS_EN
    ,
    output logic [31:0]               flit_cnt_o,
    output logic [31:0]               pkt_cnt_o
`endif
);

    localparam int               c_idx_w = $clog2(NUM_IN);
    localparam int               CNT_W   = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] c_full  = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    port_state_t        r_state, w_state_nxt;
    logic [c_idx_w-1:0] r_ptr, w_ptr_nxt;
    logic [c_idx_w-1:0] r_owner, w_owner_nxt;
    logic [c_idx_w-1:0] w_win, w_arb_idx;
    logic [NUM_IN-1:0]  w_arb_grant, w_grant;
    logic [CNT_W-1:0]   r_credits;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid, r_err;
    logic               w_can_send, w_fire;

    noc_rr_arbiter #(
        .N     (NUM_IN),
        .IDX_W (c_idx_w)
    ) u_arb (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx)
    );

    // No credit bypass: only the registered count decides; reset blocks grants.
    assign w_can_send = (r_credits != '0) && !reset;
    assign w_fire     = |w_grant;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_grant     = '0;
        w_win       = r_owner;
        case (r_state)
            IDLE: begin
                if (w_can_send && (|req_i)) begin
                    w_grant = w_arb_grant;
                    w_win   = w_arb_idx;
                    if (tail_i[w_arb_idx]) begin
                        w_ptr_nxt = c_idx_w'(wrap_inc(int'(w_arb_idx), NUM_IN));
                    end else begin
                        w_state_nxt = LOCKED;
                        w_owner_nxt = w_arb_idx;
                    end
                end
            end
            LOCKED: begin
                // A bubble from the owner keeps the lock indefinitely.
                if (w_can_send && req_i[r_owner]) begin
                    w_grant[r_owner] = 1'b1;
                    if (tail_i[r_owner]) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = c_idx_w'(wrap_inc(int'(r_owner), NUM_IN));
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_credits <= c_full;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_valid <= w_fire;
            if (w_fire) begin
                r_data <= data_i[int'(w_win)*DATA_W +: DATA_W];
            end
            case ({w_fire, credit_i})
                2'b10:   r_credits <= r_credits - c_one;
                2'b01: begin
                    if (r_credits == c_full) begin
                        r_err <= 1'b1;
                    end else begin
                        r_credits <= r_credits + c_one;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant_o = w_grant;
    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign owner_o = r_owner;
    assign err_o   = r_err;

`ifdef NOC_OUTPUT_PORT_STATS_EN
    logic [31:0] r_flit_cnt, r_pkt_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flit_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            if (w_fire) begin
                r_flit_cnt <= r_flit_cnt + 32'd1;
            end
            if (|(w_grant & tail_i)) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign flit_cnt_o = r_flit_cnt;
    assign pkt_cnt_o  = r_pkt_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_output_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_output_port
// Purpose  : Directed, self-checking bench for noc_output_port with a
//            behavioural reference model compared on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_output_port;
    import noc_pkg::*;

    localparam int NI = 5;
    localparam int DW = 16;
    localparam int CR = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NI-1:0]     req = '0, tail = '0, grant;
    logic [NI*DW-1:0]  din = '0;
    logic              credit = 1'b0;
    logic [DW-1:0]     dout;
    logic              valid, err;
    logic [2:0]        owner;
`ifdef NOC_OUTPUT_PORT_STATS_EN
    logic [31:0]       flit_cnt, pkt_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    int seq = 0;

    always #5 clk = ~clk;

    noc_output_port #(
        .NUM_IN  (NI),
        .DATA_W  (DW),
        .CREDITS (CR)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .req_i      (req),
        .tail_i     (tail),
        .data_i     (din),
        .grant_o    (grant),
        .credit_i   (credit),
        .data_o     (dout),
        .valid_o    (valid),
        .owner_o    (owner),
        .err_o      (err)
`ifdef NOC_OUTPUT_PORT_STATS_EN
        ,
        .flit_cnt_o (flit_cnt),
        .pkt_cnt_o  (pkt_cnt)
`endif
    );

    // Reference model: credit count, lock owner, rotation start, outputs.
    int             m_cred   = CR;
    int             m_owner  = 0;
    int             m_ptr    = 0;
    bit             m_locked = 1'b0;
    bit             m_valid  = 1'b0;
    bit             m_err    = 1'b0;
    logic [DW-1:0]  m_data   = '0;
    int             m_flits  = 0;
    int             m_pkts   = 0;

    function automatic int pred_winner();
        if (rst || m_cred == 0) return -1;
        if (m_locked) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < NI; k++) begin
            if (req[(m_ptr + k) % NI]) return (m_ptr + k) % NI;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        w = pred_winner();
        if (rst) begin
            m_cred = CR; m_owner = 0; m_ptr = 0; m_locked = 1'b0;
            m_valid = 1'b0; m_err = 1'b0; m_data = '0; m_flits = 0; m_pkts = 0;
        end else begin
            m_valid = (w >= 0);
            if (w >= 0) begin
                m_data = din[w*DW +: DW];
                m_flits++;
                if (tail[w]) begin
                    m_pkts++;
                    m_locked = 1'b0;
                    m_ptr = (w + 1) % NI;
                end else begin
                    m_locked = 1'b1;
                    m_owner = w;
                end
            end
            if (w >= 0 && !credit) m_cred--;
            else if (w < 0 && credit) begin
                if (m_cred == CR) m_err = 1'b1;
                else m_cred++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            int w;
            logic [NI-1:0] eg;
            w  = pred_winner();
            eg = '0;
            if (w >= 0) eg[w] = 1'b1;
            chk("grant", 32'(grant), 32'(eg));
            chk("valid", 32'(valid), 32'(m_valid));
            chk("data", 32'(dout), 32'(m_data));
            chk("err", 32'(err), 32'(m_err));
            chk("owner", 32'(owner), m_owner);
`ifdef NOC_OUTPUT_PORT_STATS_EN
            chk("flit_cnt", flit_cnt, m_flits);
            chk("pkt_cnt", pkt_cnt, m_pkts);
`endif
        end
    end

    task automatic set_in(input logic [NI-1:0] r, input logic [NI-1:0] t, input logic c);
        req = r; tail = t; credit = c; seq++;
        for (int i = 0; i < NI; i++) din[i*DW +: DW] = 16'(((i + 1) << 12) | (seq & 'hFFF));
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic step(input logic [NI-1:0] r, input logic [NI-1:0] t, input logic c,
                        input logic [NI-1:0] exp_g, input string name);
        set_in(r, t, c);
        #1;
        chk(name, 32'(grant), 32'(exp_g));
        tick();
    endtask

    logic [NI-1:0] t2_exp [4] = '{5'b01000, 5'b00001, 5'b01000, 5'b00001};
    int ng;

    initial begin
        set_in('0, '0, 1'b0);
        tick(); tick();
        cmp_en = 1'b1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_data", 32'(dout), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_owner", 32'(owner), 0);
        rst = 1'b0;

        // Single-flit packet from W.
        set_in(5'b00100, 5'b00100, 1'b0);
        din[DIR_W*DW +: DW] = 16'hA5A5;
        #1; chk("t1_grant", 32'(grant), 32'h4);
        tick();
        chk("t1_data", 32'(dout), 32'hA5A5);
        chk("t1_valid", 32'(valid), 1);
        chk("t1_cred", m_cred, 7);

        // N and E alternate; credit returned every cycle alongside the grant.
        for (int i = 0; i < 4; i++) step(5'b01001, 5'b11111, 1'b1, t2_exp[i], "t2_rr");
        chk("t2_cred", m_cred, 7);

        // 3-flit packet from S with a bubble; W waits throughout.
        step(5'b00110, 5'b00000, 1'b0, 5'b00010, "t3_head");
        step(5'b00110, 5'b00000, 1'b0, 5'b00010, "t3_body");
        chk("t3_owner", 32'(owner), 1);
        step(5'b00100, 5'b00000, 1'b0, 5'b00000, "t3_bubble");
        step(5'b00110, 5'b00010, 1'b0, 5'b00010, "t3_tail");
        step(5'b00100, 5'b00100, 1'b0, 5'b00100, "t3_next");
        chk("t3_cred", m_cred, 3);

        // Grant plus credit keeps count; then refill and overflow.
        step(5'b00001, 5'b00001, 1'b1, 5'b00001, "t5_both");
        chk("t5_cred", m_cred, 3);
        for (int i = 0; i < 5; i++) step('0, '0, 1'b1, '0, "t5_refill");
        chk("t5_err0", 32'(err), 0);
        step('0, '0, 1'b1, '0, "t5_over");
        chk("t5_err1", 32'(err), 1);
        step('0, '0, 1'b0, '0, "t5_idle");
        step('0, '0, 1'b0, '0, "t5_idle");
        chk("t5_sticky", 32'(err), 1);

        // Long packet exhausts all credits, then one credit releases one flit.
        ng = 0;
        for (int i = 0; i < 10; i++) begin
            set_in(5'b00001, 5'b00000, 1'b0);
            #1; if (grant[0]) ng++;
            tick();
        end
        chk("t4_grants", ng, CR);
        step(5'b00001, 5'b00000, 1'b1, 5'b00000, "t4_nobypass");
        step(5'b00001, 5'b00001, 1'b0, 5'b00001, "t4_after_credit");
        for (int i = 0; i < CR; i++) step('0, '0, 1'b1, '0, "t4_refill");

        // Fresh reset, two 3-flit packets from L, then reset mid-packet.
        rst = 1'b1; set_in('0, '0, 1'b0); tick(); rst = 1'b0;
        chk("r_err", 32'(err), 0);
        for (int p = 0; p < 2; p++) begin
            step(5'b10000, 5'b00000, 1'b0, 5'b10000, "s_head");
            step(5'b10000, 5'b00000, 1'b0, 5'b10000, "s_body");
            step(5'b10000, 5'b10000, 1'b0, 5'b10000, "s_tail");
        end
`ifdef NOC_OUTPUT_PORT_STATS_EN
        chk("s_flits", flit_cnt, 6);
        chk("s_pkts", pkt_cnt, 2);
`endif
        step(5'b10000, 5'b00000, 1'b0, 5'b10000, "s_head2");
        set_in(5'b11000, 5'b00000, 1'b0);
        rst = 1'b1;
        #1; chk("mr_grant", 32'(grant), 0);
        tick();
        chk("mr_valid", 32'(valid), 0);
`ifdef NOC_OUTPUT_PORT_STATS_EN
        chk("mr_flits", flit_cnt, 0);
        chk("mr_pkts", pkt_cnt, 0);
`endif
        rst = 1'b0;
        step(5'b11000, 5'b01000, 1'b0, 5'b01000, "mr_unlocked");
        step('0, '0, 1'b0, '0, "end_idle");
        tick();
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_output_port.md
Name: noc_output_port

Overview:
- Parametrised per-output slice for the next-generation mesh router. It merges the current arbiter's round-robin, next-hop and packet-tracker roles with the credit counter and crossbar output mux into one block, instanced once per output direction.
- Arbitrates NUM_IN input buffers using round-robin with wormhole packet locking.
- Tracks downstream credits and drives a registered flit/valid pair to the neighbour router or local core.

Parameters:
- NUM_IN, 5, number of requesting input ports (N,S,W,E,L order; edge routers may use 4)
- DATA_W, 16, flit width in bits
- CREDITS, 8, downstream buffer depth; credit counter reset value
- CNT_W, $clog2(CREDITS+1), credit counter width (derived, not overridable)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_i  in  NUM_IN  input buffer i non-empty and routed to this output
- tail_i  in  NUM_IN  flit presented by input i is the last flit of its packet
- data_i  in  NUM_IN*DATA_W  flit presented by each input buffer, input i at [i*DATA_W +: DATA_W]
- grant_o  out  NUM_IN  one-hot read pulse to the winning input buffer (combinational)
- credit_i  in  1  downstream freed one slot (1-cycle pulse)
- data_o  out  DATA_W  registered output flit
- valid_o  out  1  data_o valid this cycle
- owner_o  out  $clog2(NUM_IN)  current lock owner; debug only
- err_o  out  1  sticky: credit overflow

Behaviour:
- Reset: data_o=0, valid_o=0, grant_o=0, credit counter=CREDITS, FSM=IDLE, rr pointer=0, owner_o=0, err_o=0.
- Send condition: counter>0. There is no same-cycle credit bypass; credit_i arriving with counter==0 enables sending on the next cycle.
- FSM IDLE:
  - If the send condition holds and req_i!=0, grant the first requester at or after the rr pointer, wrapping modulo NUM_IN.
  - If tail_i of the winner is 1 (single-flit packet), stay IDLE and set rr pointer=winner+1 mod NUM_IN.
  - Otherwise go to LOCKED and set owner=winner.
- FSM LOCKED:
  - grant_o[owner]=req_i[owner] && send condition.
  - All other inputs get no grant, even if requesting.
  - A granted flit with tail_i[owner]=1 returns the FSM to IDLE and sets rr pointer=owner+1 mod NUM_IN.
  - A bubble (req_i[owner]=0) holds the lock with no timeout.
- Datapath:
  - The granted cycle registers data_i[winner] into data_o and asserts valid_o=1 on the next cycle (latency 1).
  - With no grant, valid_o=0 and data_o holds its previous value.
- Credit counter:
  - Decrements on a grant and increments on credit_i.
  - Grant and credit_i in the same cycle leave the counter unchanged.
  - credit_i while counter==CREDITS with no grant: counter saturates and err_o latches 1 until reset.
- Grant rules: grant_o is always one-hot or zero, and a grant is never issued while counter==0.
- Mid-packet reset: the lock is abandoned and the FSM returns to IDLE. Recovery of upstream buffers is not this block's concern.

Optional Feature:
- Macro: NOC_OUTPUT_PORT_STATS_EN.
- Defined: adds ports flit_cnt_o[31:0] and pkt_cnt_o[31:0], both free-running wrap-around counters cleared by reset.
  - flit_cnt_o increments per grant.
  - pkt_cnt_o increments per granted tail flit.
- Undefined: the ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Shared package noc_pkg holds:
  - the direction index constants DIR_N=0, DIR_S=1, DIR_W=2, DIR_E=3, DIR_L=4;
  - the default DATA_W and CREDITS values;
  - the FSM enum typedef port_state_t {IDLE, LOCKED}.
- One sub-module, noc_rr_arbiter, parametrised on N: takes req and pointer, returns a one-hot grant and the winner index. It is purely combinational.

Test Plan:
- Reset, then req_i=5'b00100 with tail=1 and data 16'hA5A5 → grant_o=00100 that cycle; next cycle data_o=A5A5 and valid_o=1; counter=7.
- Inputs 0 and 3 request continuously with single-flit packets → grants alternate 0,3,0,3; no input is granted twice in a row.
- Input 1 sends a 3-flit packet while input 2 requests throughout → input 2 is not granted until the cycle after input 1's tail flit; owner_o=1 during the packet.
- CREDITS=2, no credit_i, 4-flit packet on input 0 → exactly 2 grants, then a stall. A credit_i pulse gives one more grant on the following cycle.
- Grant and credit_i in the same cycle with counter=3 → counter stays 3. Then credit_i at counter=8 with no grant → err_o=1 and remains set; counter stays 8.
- With NOC_OUTPUT_PORT_STATS_EN defined, send 2 packets of 3 flits → flit_cnt_o=6, pkt_cnt_o=2. Assert reset mid-packet → both counters 0, FSM IDLE, valid_o=0.
